control_pc_lut: RTL and testbench

CONTROL_PC_LUT -- requirements
Module: control_pc_lut

---
 rtl/control_pc_lut.sv | 140 ++++++++++++++
 tb/tb_control_pc_lut.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/control_pc_lut.sv
// control_pc_lut: combinational instruction decoder plus program counter with a 16-entry branch-target LUT.
// Optional macro CONTROL_PC_LUT_WRITE_EN makes the LUT writable through lut_we/lut_waddr/lut_wdata.
module control_pc_lut #(
    parameter int D = 12,
    parameter int A = 4,
    parameter int DONE_ADDR = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [8:0]   mach_code,
    input  logic         branch_flag,
`ifdef CONTROL_PC_LUT_WRITE_EN
    input  logic         lut_we,
    input  logic [3:0]   lut_waddr,
    input  logic [D-1:0] lut_wdata,
`endif
    output logic [D-1:0] prog_ctr,
    output logic [1:0]   InstType,
    output logic         BranchInst,
    output logic         MemRead,
    output logic         MemWrite,
    output logic         ALUSrc,
    output logic         RegWrite,
    output logic         isaddi,
    output logic         ismovr,
    output logic         MemtoReg,
    output logic [A-1:0] ALUOp,
    output logic         done
);

    localparam logic [4:0] OP_ADDI = 5'b00111;
    localparam logic [4:0] OP_MOVR = 5'b01000;
    localparam logic [4:0] OP_LW   = 5'b01001;
    localparam logic [4:0] OP_SW   = 5'b01010;
    localparam logic [4:0] OP_CMP  = 5'b01011;
    localparam logic [4:0] OP_BR   = 5'b01100;
    localparam logic [4:0] OP_JMP  = 5'b01101;
    localparam logic [4:0] OP_BRR  = 5'b01110;
    localparam logic [4:0] OP_HALT = 5'b01111;

    logic [4:0]   opcode;
    logic [3:0]   alu_op;
    logic [D-1:0] target;
    logic [D-1:0] next_pc;
    logic [D-1:0] brr_offset;
    logic         is_br, is_jmp, is_brr, is_halt;

    assign opcode     = mach_code[8:4];
    assign is_br      = opcode == OP_BR;
    assign is_jmp     = opcode == OP_JMP;
    assign is_brr     = opcode == OP_BRR;
    assign is_halt    = opcode == OP_HALT;
    assign brr_offset = {{(D-4){mach_code[3]}}, mach_code[3:0]};

    // Power-on table: entry k points at address k*8.
    function automatic logic [D-1:0] lut_default(input logic [3:0] k);
        return D'({k, 3'b000});
    endfunction

`ifdef CONTROL_PC_LUT_WRITE_EN
    logic [D-1:0] lut [16];

    // Writable target table; a read in the write cycle still sees the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) lut[i] <= lut_default(4'(i));
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    assign target = lut[mach_code[3:0]];
`else
    assign target = lut_default(mach_code[3:0]);
`endif

    // Opcode decode; everything is held at zero while reset is asserted.
    always_comb begin
        {InstType, BranchInst, MemRead, MemWrite, ALUSrc, RegWrite, isaddi, ismovr, MemtoReg} = '0;
        alu_op = 4'b0000;
        if (opcode[4]) begin
            InstType = 2'b10;
            RegWrite = 1'b1;
        end else begin
            case (opcode)
                OP_ADDI: begin
                    isaddi   = 1'b1;
                    ALUSrc   = 1'b1;
                    RegWrite = 1'b1;
                end
                OP_MOVR: begin
                    ismovr   = 1'b1;
                    InstType = 2'b01;
                    RegWrite = 1'b1;
                    alu_op   = 4'b0111;
                end
                OP_LW: begin
                    MemRead  = 1'b1;
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    alu_op   = 4'b1000;
                end
                OP_SW: begin
                    MemWrite = 1'b1;
                    alu_op   = 4'b1000;
                end
                OP_CMP:         alu_op = 4'b0001;
                OP_BR, OP_JMP:  BranchInst = 1'b1;
                OP_BRR, OP_HALT: ;
                default: begin
                    RegWrite = 1'b1;
                    alu_op   = opcode[3:0];
                end
            endcase
        end
        if (!reset) begin
            {InstType, BranchInst, MemRead, MemWrite, ALUSrc, RegWrite, isaddi, ismovr, MemtoReg} = '0;
            alu_op = 4'b0000;
        end
    end

    assign ALUOp = A'(alu_op);

    // Next-PC priority: halt, taken absolute branch, taken relative branch, sequential.
    always_comb begin
        next_pc = prog_ctr + D'(1);
        if (is_halt) next_pc = prog_ctr;
        else if ((is_br && branch_flag) || is_jmp) next_pc = target;
        else if (is_brr && branch_flag) next_pc = prog_ctr + brr_offset;
    end

    // Program counter; asynchronous reset overrides any pending branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prog_ctr <= '0;
        else        prog_ctr <= next_pc;
    end

    assign done = reset && (prog_ctr == D'(DONE_ADDR) || is_halt);

endmodule

// File: tb/tb_control_pc_lut.sv
// tb_control_pc_lut: directed self-checking bench for control_pc_lut (LUT-write checks under CONTROL_PC_LUT_WRITE_EN).
module tb_control_pc_lut;
    localparam int D = 12;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [8:0]   mach_code = 9'b0;
    logic         branch_flag = 1'b0;
    logic [D-1:0] prog_ctr;
    logic [1:0]   InstType;
    logic         BranchInst, MemRead, MemWrite, ALUSrc, RegWrite, isaddi, ismovr, MemtoReg, done;
    logic [A-1:0] ALUOp;
`ifdef CONTROL_PC_LUT_WRITE_EN
    logic         lut_we = 1'b0;
    logic [3:0]   lut_waddr = 4'd0;
    logic [D-1:0] lut_wdata = '0;
`endif

    int total = 0;
    int bad = 0;

    logic [13:0] ctl;
    assign ctl = {InstType, BranchInst, MemRead, MemWrite, ALUSrc, RegWrite, isaddi, ismovr, MemtoReg, ALUOp};

    // Expected control words, indexed by opcode 0..16 (16 stands for LI 10000).
    logic [13:0] exp_ctl [17] = '{
        14'h0080, 14'h0081, 14'h0082, 14'h0083, 14'h0084, 14'h0085, 14'h0086, 14'h01C0,
        14'h10A7, 14'h0498, 14'h0208, 14'h0001, 14'h0800, 14'h0800, 14'h0000, 14'h0000,
        14'h2080
    };

    control_pc_lut #(.D(D), .A(A), .DONE_ADDR(9)) dut (
        .clk(clk), .reset(reset), .mach_code(mach_code), .branch_flag(branch_flag),
`ifdef CONTROL_PC_LUT_WRITE_EN
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
`endif
        .prog_ctr(prog_ctr), .InstType(InstType), .BranchInst(BranchInst), .MemRead(MemRead),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .isaddi(isaddi),
        .ismovr(ismovr), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply an instruction at a falling edge and return at the next falling edge.
    task automatic step(input logic [8:0] code, input logic flag);
        mach_code = code;
        branch_flag = flag;
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_pc", prog_ctr, 0);
        chk("rst_done", done, 0);
        chk("rst_ctl", ctl, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            chk($sformatf("seq_pc%0d", i), prog_ctr, i);
            chk($sformatf("seq_done%0d", i), done, i == 9);
            @(negedge clk);
        end
        for (int op = 0; op <= 16; op++) begin
            mach_code = {5'(op), 4'b0000};
            #1;
            chk($sformatf("ctl_op%0d", op), ctl, exp_ctl[op]);
            if (op == 15) chk("halt_done", done, 1);
            @(negedge clk);
        end
        reset = 1'b0;
        mach_code = 9'b0;
        #1;
        chk("rst2_pc", prog_ctr, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) step(9'b000000000, 1'b0);
        chk("pc5", prog_ctr, 5);
        step(9'b011000011, 1'b0);
        chk("br_nt", prog_ctr, 6);
        step(9'b011000011, 1'b1);
        chk("br_t", prog_ctr, 24);
        step(9'b011010010, 1'b0);
        chk("jmp_f0", prog_ctr, 16);
        step(9'b011010010, 1'b1);
        chk("jmp_f1", prog_ctr, 16);
        step(9'b011010000, 1'b0);
        chk("jmp0", prog_ctr, 0);
        repeat (7) step(9'b000000000, 1'b0);
        chk("pc7", prog_ctr, 7);
        step(9'b011101110, 1'b1);
        chk("brr_m2", prog_ctr, 5);
        step(9'b011101110, 1'b0);
        chk("brr_nt", prog_ctr, 6);
        step(9'b011100000, 1'b1);
        chk("brr_self", prog_ctr, 6);
        step(9'b011010000, 1'b0);
        step(9'b011101111, 1'b1);
        chk("brr_wrap", prog_ctr, 12'hFFF);
        step(9'b000000000, 1'b0);
        chk("inc_wrap", prog_ctr, 0);
        repeat (4) step(9'b000000000, 1'b0);
        chk("pc4", prog_ctr, 4);
        step(9'b011110000, 1'b0);
        chk("halt_pc", prog_ctr, 4);
        chk("halt_dn", done, 1);
        step(9'b011110000, 1'b1);
        chk("halt_pc2", prog_ctr, 4);
        #2;
        reset = 1'b0;
        #1;
        chk("async_pc", prog_ctr, 0);
        chk("async_done", done, 0);
        mach_code = 9'b011010010;
        branch_flag = 1'b1;
        #1;
        chk("async_ctl", ctl, 0);
        @(negedge clk);
        chk("rst_jmp", prog_ctr, 0);
        mach_code = 9'b000000000;
        reset = 1'b1;
        @(negedge clk);
        chk("first_fetch", prog_ctr, 1);
`ifdef CONTROL_PC_LUT_WRITE_EN
        lut_we = 1'b1;
        lut_waddr = 4'd3;
        lut_wdata = 12'h100;
        step(9'b011000011, 1'b1);
        chk("wr_old", prog_ctr, 24);
        lut_we = 1'b0;
        step(9'b011000011, 1'b1);
        chk("wr_new", prog_ctr, 12'h100);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clk);
        step(9'b011000011, 1'b1);
        chk("wr_rst", prog_ctr, 24);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
